// File: rtl/dcache_sram_nway.sv
// N-way set-associative L1 data-cache tag/data store with true-LRU replacement and flush walk.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_sram_nway #(
  parameter int unsigned SETS   = 16,
  parameter int unsigned WAYS   = 2,
  parameter int unsigned TAG_W  = 23,
  parameter int unsigned LINE_W = 256,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned AGE_W = $clog2(WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic              fill_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic              hit_o,
  output logic [LINE_W-1:0] data_o,
  output logic              victim_valid_o,
  output logic [TAG_W-1:0]  victim_tag_o,
  output logic [LINE_W-1:0] victim_data_o,
  input  logic              flush_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [IDX_W-1:0]  wb_idx_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0][WAYS-1:0]             valid_q, dirty_q;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]  age_q;
  logic [TAG_W-1:0]                      tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0]                     data_mem [SETS][WAYS];

  logic [IDX_W-1:0] fl_set_q, fl_set_d;
  logic [AGE_W-1:0] fl_way_q, fl_way_d;
  logic             fl_clr, fl_wb;

  logic                       accept, hit, any_inv, do_touch;
  logic [AGE_W-1:0]           hit_way, inv_way, lru_way, cand_way, sel_way, touch_way;
  logic [WAYS-1:0][AGE_W-1:0] age_new;
  logic                       sel_valid;

  assign accept = req_i && (state_q == ST_IDLE);

  // Tag compare, lowest invalid way and oldest way of the addressed set
  always_comb begin
    hit     = 1'b0;
    any_inv = 1'b0;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[addr_i][w] && (tag_mem[addr_i][w] == tag_i)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_q[addr_i][w] && !any_inv) begin
        any_inv = 1'b1;
        inv_way = AGE_W'(w);
      end
      if (age_q[addr_i][w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
  end

  assign cand_way  = any_inv ? inv_way : lru_way;
  assign sel_way   = (fill_i && hit) ? hit_way : cand_way;
  assign touch_way = fill_i ? sel_way : hit_way;
  assign do_touch  = accept && (fill_i || hit);
  assign sel_valid = valid_q[addr_i][sel_way];

  // Touched way becomes youngest; younger ways than it age by one
  always_comb begin
    age_new = age_q[addr_i];
    for (int w = 0; w < int'(WAYS); w++) begin
      if (age_q[addr_i][w] < age_q[addr_i][touch_way]) age_new[w] = age_q[addr_i][w] + AGE_W'(1);
    end
    age_new[touch_way] = '0;
  end

  assign fl_wb = (state_q == ST_FLUSH) && valid_q[fl_set_q][fl_way_q] && dirty_q[fl_set_q][fl_way_q];

  always_comb begin
    state_d  = state_q;
    fl_set_d = fl_set_q;
    fl_way_d = fl_way_q;
    fl_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i && !req_i) begin
          state_d  = ST_FLUSH;
          fl_set_d = '0;
          fl_way_d = '0;
        end
      end
      ST_FLUSH: begin
        if (!fl_wb || wb_ready_i) begin
          fl_clr   = 1'b1;
          fl_way_d = fl_way_q + AGE_W'(1);
          if (fl_way_q == AGE_W'(WAYS - 1)) begin
            if (fl_set_q == IDX_W'(SETS - 1)) begin
              state_d  = ST_IDLE;
              fl_way_d = fl_way_q;
            end else begin
              fl_set_d = fl_set_q + IDX_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      fl_set_q <= '0;
      fl_way_q <= '0;
      ready_o  <= 1'b1;
    end else begin
      state_q  <= state_d;
      fl_set_q <= fl_set_d;
      fl_way_q <= fl_way_d;
      ready_o  <= (state_d == ST_IDLE);
    end
  end

  // Line state: valid/dirty and LRU ages
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      if (accept && fill_i) begin
        valid_q[addr_i][sel_way] <= 1'b1;
        dirty_q[addr_i][sel_way] <= we_i;
      end else if (accept && we_i && hit) begin
        dirty_q[addr_i][hit_way] <= 1'b1;
      end
      if (do_touch) age_q[addr_i] <= age_new;
      if (fl_clr) begin
        valid_q[fl_set_q][fl_way_q] <= 1'b0;
        dirty_q[fl_set_q][fl_way_q] <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset
  always_ff @(posedge clk_i) begin
    if (accept && fill_i) begin
      tag_mem[addr_i][sel_way]  <= tag_i;
      data_mem[addr_i][sel_way] <= data_i;
    end else if (accept && we_i && hit) begin
      data_mem[addr_i][hit_way] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o        <= 1'b0;
      hit_o          <= 1'b0;
      data_o         <= '0;
      victim_valid_o <= 1'b0;
      victim_tag_o   <= '0;
      victim_data_o  <= '0;
    end else begin
      valid_o        <= accept;
      hit_o          <= accept && hit;
      data_o         <= (accept && hit && !we_i && !fill_i) ? data_mem[addr_i][hit_way] : '0;
      victim_valid_o <= accept && !hit && sel_valid && dirty_q[addr_i][sel_way];
      victim_tag_o   <= (accept && sel_valid) ? tag_mem[addr_i][sel_way] : '0;
      victim_data_o  <= (accept && sel_valid) ? data_mem[addr_i][sel_way] : '0;
    end
  end

  assign wb_valid_o = fl_wb;
  assign wb_idx_o   = fl_wb ? fl_set_q : '0;
  assign wb_tag_o   = fl_wb ? tag_mem[fl_set_q][fl_way_q] : '0;
  assign wb_data_o  = fl_wb ? data_mem[fl_set_q][fl_way_q] : '0;

`ifdef DCACHE_STATS_EN
  // Saturating lookup statistics; fills are not lookups
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (accept && !fill_i) begin
      if (hit && (hit_cnt_o != 32'hFFFF_FFFF))   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (!hit && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule
